// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// The image header is a 32-bit little-endian byte count.
package instr_loader_pkg;

   typedef enum logic [2:0] {HDR, DATA, CHK, DONE, ERR} ldr_state_t;

   localparam int HDR_BYTES = 4;
   localparam int LEN_WIDTH = 32;

endpackage

// File: rtl/ldr_checksum.sv
// Running modulo-2**D_WIDTH sum of payload bytes with a zero test
// that folds in the byte currently on the bus (the checksum trailer).
module ldr_checksum #(
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               acc_en,
   input  logic [D_WIDTH-1:0] acc_data,
   output logic               sum_zero
);

   logic [D_WIDTH-1:0] sum;
   logic [D_WIDTH-1:0] total;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum <= '0;
      end else if (clear) begin
         sum <= '0;
      end else if (acc_en) begin
         sum <= sum + acc_data;
      end
   end

   // The carry out is deliberately dropped: the check is modulo 2**D_WIDTH.
   assign total    = sum + acc_data;
   assign sum_zero = (total == '0);

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: holds the core in reset, streams a length-prefixed, checksummed
// image into instruction memory, then hands the memory address port to the core.
module instr_mem_loader
   import instr_loader_pkg::*;
#(
   parameter int A_WIDTH = 28,
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_start,
   input  logic [D_WIDTH-1:0] rx_data,
   input  logic               rx_valid,
   output logic               rx_ready,
   input  logic [A_WIDTH-1:0] pc_addr,
   output logic [A_WIDTH-1:0] mem_addr,
   output logic               mem_we,
   output logic [D_WIDTH-1:0] mem_wdata,
   output logic               cpu_hold,
   output logic               load_done,
   output logic               load_err
);

   // One extra bit so an image of exactly 2**A_WIDTH bytes neither wraps the
   // write pointer nor aliases the remaining count before the trailer arrives.
   localparam int CNT_W = A_WIDTH + 1;
   localparam logic [LEN_WIDTH:0] MAX_LEN = (LEN_WIDTH+1)'(1) << A_WIDTH;

   ldr_state_t           state;
   logic [LEN_WIDTH-1:0] len;
   logic [LEN_WIDTH-1:0] new_len;
   logic [1:0]           hdr_cnt;
   logic [CNT_W-1:0]     wr_ptr;
   logic [CNT_W-1:0]     remaining;
   logic                 accept;
   logic                 restart;
   logic                 last_hdr;
   logic                 sum_zero;

   assign accept   = rx_valid && rx_ready;
   assign restart  = load_start && ((state == DONE) || (state == ERR));
   assign last_hdr = (hdr_cnt == 2'(HDR_BYTES - 1));
   assign new_len  = {rx_data, len[LEN_WIDTH-1:D_WIDTH]};

   ldr_checksum #(.D_WIDTH(D_WIDTH)) u_checksum (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (restart),
      .acc_en   (accept && (state == DATA)),
      .acc_data (rx_data),
      .sum_zero (sum_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HDR;
         len       <= '0;
         hdr_cnt   <= '0;
         wr_ptr    <= '0;
         remaining <= '0;
      end else begin
         case (state)
            HDR: begin
               if (accept) begin
                  len     <= new_len;
                  hdr_cnt <= hdr_cnt + 2'd1;
                  if (last_hdr) begin
                     remaining <= CNT_W'(new_len);
                     if ({1'b0, new_len} > MAX_LEN) begin
                        state <= ERR;
                     end else if (new_len == '0) begin
                        state <= CHK;
                     end else begin
                        state <= DATA;
                     end
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  wr_ptr    <= wr_ptr + CNT_W'(1);
                  remaining <= remaining - CNT_W'(1);
                  if (remaining == CNT_W'(1)) begin
                     state <= CHK;
                  end
               end
            end
            CHK: begin
               if (accept) begin
                  state <= sum_zero ? DONE : ERR;
               end
            end
            DONE, ERR: begin
               if (load_start) begin
                  state     <= HDR;
                  len       <= '0;
                  hdr_cnt   <= '0;
                  wr_ptr    <= '0;
                  remaining <= '0;
               end
            end
            default: begin
               state <= HDR;
            end
         endcase
      end
   end

   // Memory port belongs to the core only once a verified image is in place.
   assign rx_ready  = (state == HDR) || (state == DATA) || (state == CHK);
   assign mem_we    = (state == DATA) && rx_valid;
   assign mem_wdata = rx_data;
   assign mem_addr  = (state == DONE) ? pc_addr : wr_ptr[A_WIDTH-1:0];
   assign cpu_hold  = (state != DONE);
   assign load_done = (state == DONE);
   assign load_err  = (state == ERR);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader, built with a 16-byte
// memory so the length-overflow and exact-fill boundaries are cheap to reach.
module tb_instr_mem_loader;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;

   typedef logic [7:0] byteq_t [$];

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load_start;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [AW-1:0] pc_addr;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic          cpu_hold;
   logic          load_done;
   logic          load_err;

   int            vectors;
   int            miscompares;
   int            write_count;
   logic [7:0]    dev_mem [DEPTH];
   logic [7:0]    ref_mem [DEPTH];
   byteq_t        img;

   instr_mem_loader #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .pc_addr    (pc_addr),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   always #5 clk = ~clk;

   // Stand-in for the instruction memory: records what the loader writes.
   always @(posedge clk) begin
      if (mem_we === 1'b1) begin
         dev_mem[mem_addr] = mem_wdata;
         write_count = write_count + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors = vectors + 1;
      if (actual !== expected) begin
         miscompares = miscompares + 1;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   function automatic byteq_t makeImage(input logic [31:0] len, input bit good);
      byteq_t     q;
      logic [7:0] s;
      logic [7:0] b;
      s = 8'h00;
      for (int i = 0; i < 4; i++) q.push_back(len[8*i +: 8]);
      if (len <= DEPTH) begin
         for (int i = 0; i < int'(len); i++) begin
            b = 8'($urandom);
            q.push_back(b);
            s = s + b;
         end
         b = 8'h00 - s;
         if (!good) b = b + 8'($urandom_range(1, 255));
         q.push_back(b);
      end
      return q;
   endfunction

   task automatic checkReset();
      checkOutput("rst_rx_ready", rx_ready, 1'b1);
      checkOutput("rst_mem_we", mem_we, 1'b0);
      checkOutput("rst_mem_addr", mem_addr, '0);
      checkOutput("rst_cpu_hold", cpu_hold, 1'b1);
      checkOutput("rst_load_done", load_done, 1'b0);
      checkOutput("rst_load_err", load_err, 1'b0);
   endtask

   task automatic doReset();
      rst_n      = 1'b0;
      rx_valid   = 1'b0;
      load_start = 1'b0;
      pc_addr    = 4'hA;
      #1;
      checkReset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic restartLoad();
      @(negedge clk);
      load_start = 1'b1;
      pc_addr    = 4'($urandom_range(1, 15));
      @(negedge clk);
      load_start = 1'b0;
      #1;
      checkOutput("restart_cpu_hold", cpu_hold, 1'b1);
      checkOutput("restart_rx_ready", rx_ready, 1'b1);
      checkOutput("restart_load_done", load_done, 1'b0);
      checkOutput("restart_load_err", load_err, 1'b0);
      checkOutput("restart_mem_addr", mem_addr, '0);
   endtask

   // Streams one image and checks every cycle against the image-format rules.
   task automatic applyStimulus(input byteq_t im, input int bubble_pct);
      logic [31:0] len;
      logic [7:0]  total;
      bit          ovf;
      bit          ok;
      int          nsend;
      int          exp_writes;
      len   = {im[3], im[2], im[1], im[0]};
      ovf   = (len > DEPTH);
      nsend = ovf ? 4 : 4 + int'(len) + 1;
      total = 8'h00;
      write_count = 0;
      for (int i = 0; i < nsend; i++) begin
         while ($urandom_range(99) < bubble_pct) begin
            @(negedge clk);
            rx_valid   = 1'b0;
            rx_data    = 8'($urandom);
            load_start = 1'b0;
            #1;
            checkOutput("bubble_mem_we", mem_we, 1'b0);
            checkOutput("bubble_rx_ready", rx_ready, 1'b1);
         end
         @(negedge clk);
         rx_valid   = 1'b1;
         rx_data    = im[i];
         load_start = ($urandom_range(3) == 0);
         pc_addr    = 4'($urandom);
         #1;
         checkOutput("rx_ready", rx_ready, 1'b1);
         checkOutput("cpu_hold", cpu_hold, 1'b1);
         checkOutput("load_done", load_done, 1'b0);
         if (i >= 4) total = total + im[i];
         if (i >= 4 && i < 4 + int'(len)) begin
            checkOutput("data_mem_we", mem_we, 1'b1);
            checkOutput("data_mem_addr", mem_addr, i - 4);
            checkOutput("data_mem_wdata", mem_wdata, im[i]);
            ref_mem[i-4] = im[i];
         end else begin
            checkOutput("nodata_mem_we", mem_we, 1'b0);
            if (i < 4) checkOutput("hdr_mem_addr", mem_addr, '0);
         end
      end
      @(negedge clk);
      rx_valid   = 1'b0;
      load_start = 1'b0;
      #1;
      ok = !ovf && (total == 8'h00);
      exp_writes = ovf ? 0 : int'(len);
      checkOutput("end_load_done", load_done, ok);
      checkOutput("end_load_err", load_err, !ok);
      checkOutput("end_cpu_hold", cpu_hold, !ok);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         rx_valid = 1'b1;
         rx_data  = 8'($urandom);
         pc_addr  = 4'($urandom);
         #1;
         checkOutput("idle_rx_ready", rx_ready, 1'b0);
         checkOutput("idle_mem_we", mem_we, 1'b0);
         if (ok) checkOutput("done_mem_addr", mem_addr, pc_addr);
         else    checkOutput("err_mem_addr", mem_addr, ovf ? 32'd0 : 32'(len[AW-1:0]));
      end
      @(negedge clk);
      rx_valid = 1'b0;
      #1;
      checkOutput("write_count", write_count, exp_writes);
      for (int k = 0; k < exp_writes; k++) begin
         checkOutput("mem_contents", dev_mem[k], ref_mem[k]);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      write_count = 0;
      rx_data     = 8'h00;
      doReset();

      // Reference image; a sum of 0xB6 makes 0x4A the only passing trailer.
      img = {8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'h4A};
      applyStimulus(img, 0);
      restartLoad();
      img[12] = 8'h5C;
      applyStimulus(img, 0);
      restartLoad();
      img[12] = 8'h4B;
      applyStimulus(img, 0);

      restartLoad();
      img = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      applyStimulus(img, 0);
      restartLoad();
      img = {8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      applyStimulus(img, 0);

      restartLoad();
      applyStimulus(makeImage(32'd17, 1'b1), 0);
      restartLoad();
      applyStimulus(makeImage(32'd16, 1'b1), 0);
      restartLoad();
      applyStimulus(makeImage(32'h1000_0000, 1'b1), 0);

      restartLoad();
      img = {8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'h4A};
      applyStimulus(img, 50);

      // Asynchronous reset after three payload bytes, then a fresh image.
      restartLoad();
      img = makeImage(32'd8, 1'b1);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         rx_valid = 1'b1;
         rx_data  = img[i];
      end
      @(negedge clk);
      rx_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkReset();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(makeImage(32'd10, 1'b1), 0);

      for (int t = 0; t < 24; t++) begin
         restartLoad();
         if ($urandom_range(7) == 0)
            applyStimulus(makeImage(32'($urandom_range(17, 40)), 1'b1), 30);
         else
            applyStimulus(makeImage(32'($urandom_range(0, DEPTH)), $urandom_range(3) != 0), 30);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
